gate_door_ctrl: RTL and testbench

//  Downstream of the fare FSM: consumes its 1-cycle `open` grant and drives the gate

---
 rtl/gate_door_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_gate_door_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/gate_door_ctrl.sv
// -----------------------------------------------------------------------------
// gate_door_ctrl
//
// Gate door motor sequencer that sits downstream of the fare FSM. A one-cycle
// `open` grant starts the door travelling open. The door is held open until the
// paid passengers have crossed or a hold timeout expires, and is then closed.
// It reopens if the door edge is obstructed while closing. Fares that arrive
// while the door is already moving or open are stacked as credits, saturating
// at 3. Tailgating (a crossing with the door shut) and timeouts that leave
// credit unused both raise a one-cycle alarm.
//
// Parameters
//   TRAVEL_CYCLES  cycles for a full open or close stroke (>=1)
//   HOLD_CYCLES    idle cycles the door stays open before closing (>=1)
//   TMR_W          timer width; must hold max(TRAVEL_CYCLES, HOLD_CYCLES)
//
// Ports
//   clk          in   system clock; all logic on the rising edge
//   reset        in   synchronous, active-high reset
//   open         in   fare granted (one-cycle pulse)
//   maintenance  in   level; take the gate out of service
//   pass_sensor  in   level; high while a body is in the aisle
//   obstruct     in   level; door edge blocked
//   motor_open   out  drive the motor in the open direction
//   motor_close  out  drive the motor in the close direction
//   door_is_open out  door fully open
//   ready        out  gate idle and closed; a new fare may be granted
//   alarm        out  one-cycle pulse: tailgate, or timeout with unused credit
//   credits      out  outstanding paid crossings (saturates at 3)
//   pass_total   out  16-bit count of crossings that consumed a credit
//                     (only present when GATE_PASS_COUNT_EN is defined)
//
// Build option
//   GATE_PASS_COUNT_EN  adds the pass_total port and its wrapping counter.
// -----------------------------------------------------------------------------
module gate_door_ctrl #(
    parameter int TRAVEL_CYCLES = 4,
    parameter int HOLD_CYCLES   = 8,
    parameter int TMR_W         = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        open,
    input  logic        maintenance,
    input  logic        pass_sensor,
    input  logic        obstruct,
    output logic        motor_open,
    output logic        motor_close,
    output logic        door_is_open,
    output logic        ready,
    output logic        alarm,
    output logic [1:0]  credits
`ifdef GATE_PASS_COUNT_EN
    ,
    output logic [15:0] pass_total
`endif
);

    typedef enum logic [2:0] {
        ST_CLOSED,
        ST_OPENING,
        ST_OPEN,
        ST_CLOSING,
        ST_MAINT
    } state_t;

    localparam logic [TMR_W-1:0] TRAVEL_LAST = TMR_W'(TRAVEL_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(HOLD_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [TMR_W-1:0] timer_reg, timer_next;
    logic [1:0]       credits_reg, credits_next;
    logic             pass_prev_reg;
    logic             alarm_next;
    logic             pass_consumed;

    logic             motor_open_reg;
    logic             motor_close_reg;
    logic             door_is_open_reg;
    logic             ready_reg;
    logic             alarm_reg;

    logic             pass_event;
    logic             has_credit;
    logic [1:0]       credits_inc;
    logic             reopen_fare;

    assign pass_event  = pass_sensor & ~pass_prev_reg;
    assign has_credit  = (credits_reg != 2'd0);
    assign credits_inc = (credits_reg == 2'd3) ? 2'd3 : credits_reg + 2'd1;
    // A fare arriving while the gate is being closed for service does not
    // reopen the door and earns no credit; an obstruction still does reopen.
    assign reopen_fare = open & ~maintenance;

    always_comb begin
        state_next    = state_reg;
        timer_next    = timer_reg;
        credits_next  = credits_reg;
        alarm_next    = 1'b0;
        pass_consumed = 1'b0;

        case (state_reg)
            ST_CLOSED: begin
                timer_next = '0;
                // Anyone crossing a shut gate is a tailgater.
                alarm_next = pass_event;
                if (maintenance) begin
                    state_next = ST_MAINT;
                end else if (open) begin
                    state_next   = ST_OPENING;
                    credits_next = 2'd1;
                end
            end

            ST_OPENING: begin
                if (maintenance) begin
                    state_next   = ST_CLOSING;
                    credits_next = 2'd0;
                    timer_next   = '0;
                end else begin
                    if (open) begin
                        credits_next = credits_inc;
                    end
                    if (timer_reg == TRAVEL_LAST) begin
                        state_next = ST_OPEN;
                        timer_next = '0;
                    end else begin
                        timer_next = timer_reg + TMR_W'(1);
                    end
                end
            end

            ST_OPEN: begin
                if (maintenance) begin
                    state_next   = ST_CLOSING;
                    credits_next = 2'd0;
                    timer_next   = '0;
                end else if (pass_event && has_credit && open) begin
                    // One crossing paid for, one fare added: balance unchanged.
                    pass_consumed = 1'b1;
                    timer_next    = '0;
                end else if (pass_event && has_credit) begin
                    pass_consumed = 1'b1;
                    credits_next  = credits_reg - 2'd1;
                    timer_next    = '0;
                    // Last paid passenger through: start closing straight away.
                    if (credits_reg == 2'd1) begin
                        state_next = ST_CLOSING;
                    end
                end else if (open) begin
                    credits_next = credits_inc;
                    timer_next   = '0;
                end else if (timer_reg == HOLD_LAST) begin
                    // Paid-for crossings that never happened are flagged and
                    // forfeited.
                    state_next   = ST_CLOSING;
                    timer_next   = '0;
                    credits_next = 2'd0;
                    alarm_next   = has_credit;
                end else begin
                    timer_next = timer_reg + TMR_W'(1);
                end
            end

            ST_CLOSING: begin
                if (obstruct || reopen_fare) begin
                    state_next = ST_OPENING;
                    timer_next = '0;
                    if (reopen_fare) begin
                        credits_next = credits_inc;
                    end
                end else if (timer_reg == TRAVEL_LAST) begin
                    // A pending service request is picked up from CLOSED.
                    state_next = ST_CLOSED;
                    timer_next = '0;
                end else begin
                    timer_next = timer_reg + TMR_W'(1);
                end
            end

            ST_MAINT: begin
                timer_next   = '0;
                credits_next = 2'd0;
                alarm_next   = pass_event;
                if (!maintenance) begin
                    state_next = ST_CLOSED;
                end
            end

            default: begin
                state_next   = ST_CLOSED;
                timer_next   = '0;
                credits_next = 2'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so that each registered output
    // lines up with the cycle in which its state is occupied.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_CLOSED;
            timer_reg        <= '0;
            credits_reg      <= 2'd0;
            pass_prev_reg    <= 1'b0;
            motor_open_reg   <= 1'b0;
            motor_close_reg  <= 1'b0;
            door_is_open_reg <= 1'b0;
            ready_reg        <= 1'b1;
            alarm_reg        <= 1'b0;
        end else begin
            state_reg        <= state_next;
            timer_reg        <= timer_next;
            credits_reg      <= credits_next;
            pass_prev_reg    <= pass_sensor;
            motor_open_reg   <= (state_next == ST_OPENING);
            motor_close_reg  <= (state_next == ST_CLOSING);
            door_is_open_reg <= (state_next == ST_OPEN);
            ready_reg        <= (state_next == ST_CLOSED);
            alarm_reg        <= alarm_next;
        end
    end

    assign motor_open   = motor_open_reg;
    assign motor_close  = motor_close_reg;
    assign door_is_open = door_is_open_reg;
    assign ready        = ready_reg;
    assign alarm        = alarm_reg;
    assign credits      = credits_reg;

`ifdef GATE_PASS_COUNT_EN
    logic [15:0] pass_total_reg;

    // Lifetime counter: wraps naturally and survives maintenance.
    always_ff @(posedge clk) begin
        if (reset) begin
            pass_total_reg <= 16'd0;
        end else if (pass_consumed) begin
            pass_total_reg <= pass_total_reg + 16'd1;
        end
    end

    assign pass_total = pass_total_reg;
`else
    logic unused_pass_consumed;
    assign unused_pass_consumed = pass_consumed;
`endif

endmodule

// File: tb/tb_gate_door_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gate_door_ctrl
//
// Directed bench for gate_door_ctrl with TRAVEL_CYCLES=4, HOLD_CYCLES=8.
// Inputs change 1 ns after a rising edge; each step waits for the next edge and
// compares the packed output vector {motor_open, motor_close, door_is_open,
// ready, alarm, credits} against a hand-derived expectation.
// -----------------------------------------------------------------------------
module tb_gate_door_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        open;
    logic        maintenance;
    logic        pass_sensor;
    logic        obstruct;
    logic        motor_open;
    logic        motor_close;
    logic        door_is_open;
    logic        ready;
    logic        alarm;
    logic [1:0]  credits;
`ifdef GATE_PASS_COUNT_EN
    logic [15:0] pass_total;
`endif

    int total  = 0;
    int passed = 0;
    int exp_pass_total = 0;

    localparam int K_CLOSED  = 0;
    localparam int K_OPENING = 1;
    localparam int K_OPEN    = 2;
    localparam int K_CLOSING = 3;
    localparam int K_MAINT   = 4;

    gate_door_ctrl #(
        .TRAVEL_CYCLES(4),
        .HOLD_CYCLES  (8),
        .TMR_W        (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .open        (open),
        .maintenance (maintenance),
        .pass_sensor (pass_sensor),
        .obstruct    (obstruct),
        .motor_open  (motor_open),
        .motor_close (motor_close),
        .door_is_open(door_is_open),
        .ready       (ready),
        .alarm       (alarm),
        .credits     (credits)
`ifdef GATE_PASS_COUNT_EN
        ,
        .pass_total  (pass_total)
`endif
    );

    always #5 clk = ~clk;

    // Expected {motor_open, motor_close, door_is_open, ready} per state.
    function automatic logic [6:0] mk(int k, logic alm, logic [1:0] c);
        logic [3:0] s;
        case (k)
            K_CLOSED:  s = 4'b0001;
            K_OPENING: s = 4'b1000;
            K_OPEN:    s = 4'b0010;
            K_CLOSING: s = 4'b0100;
            default:   s = 4'b0000;
        endcase
        return {s, alm, c};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step(input string tag, input int k, input logic alm, input logic [1:0] c);
        logic [6:0] obs;
        @(posedge clk);
        #1;
        obs = {motor_open, motor_close, door_is_open, ready, alarm, credits};
        $display("[%0t] %s outputs=%b expect=%b", $time, tag, obs, mk(k, alm, c));
        chk(tag, {9'd0, obs}, {9'd0, mk(k, alm, c)});
    endtask

    task automatic steps(input string tag, input int n, input int k, input logic [1:0] c);
        repeat (n) step(tag, k, 1'b0, c);
    endtask

    initial begin
        reset = 1'b1; open = 1'b0; maintenance = 1'b0;
        pass_sensor = 1'b0; obstruct = 1'b0;

        // Reset and idle
        step("reset_hold", K_CLOSED, 1'b0, 2'd0);
        step("reset_hold2", K_CLOSED, 1'b0, 2'd0);
        reset = 1'b0;
        steps("idle", 5, K_CLOSED, 2'd0);

        // Reset during door travel returns straight to closed
        open = 1'b1;
        step("rst_trav_open", K_OPENING, 1'b0, 2'd1);
        open = 1'b0;
        step("rst_trav_opening", K_OPENING, 1'b0, 2'd1);
        reset = 1'b1;
        step("rst_trav_reset", K_CLOSED, 1'b0, 2'd0);
        reset = 1'b0;
        step("rst_trav_after", K_CLOSED, 1'b0, 2'd0);

        // Single fare, single crossing
        open = 1'b1;
        step("one_opening", K_OPENING, 1'b0, 2'd1);
        open = 1'b0;
        steps("one_opening", 3, K_OPENING, 2'd1);
        steps("one_open", 3, K_OPEN, 2'd1);
        pass_sensor = 1'b1;
        step("one_pass", K_CLOSING, 1'b0, 2'd0);
        exp_pass_total++;
        step("one_closing", K_CLOSING, 1'b0, 2'd0);
        pass_sensor = 1'b0;
        steps("one_closing", 2, K_CLOSING, 2'd0);
        step("one_closed", K_CLOSED, 1'b0, 2'd0);

        // Stacked fare, one crossing, hold timeout with credit left
        open = 1'b1;
        step("stack_opening", K_OPENING, 1'b0, 2'd1);
        open = 1'b0;
        step("stack_opening", K_OPENING, 1'b0, 2'd1);
        open = 1'b1;
        step("stack_second_fare", K_OPENING, 1'b0, 2'd2);
        open = 1'b0;
        step("stack_opening", K_OPENING, 1'b0, 2'd2);
        step("stack_open", K_OPEN, 1'b0, 2'd2);
        pass_sensor = 1'b1;
        step("stack_pass", K_OPEN, 1'b0, 2'd1);
        exp_pass_total++;
        pass_sensor = 1'b0;
        steps("stack_hold", 7, K_OPEN, 2'd1);
        step("stack_timeout_alarm", K_CLOSING, 1'b1, 2'd0);
        step("stack_alarm_clear", K_CLOSING, 1'b0, 2'd0);
        steps("stack_closing", 2, K_CLOSING, 2'd0);
        step("stack_closed", K_CLOSED, 1'b0, 2'd0);

        // Obstruction on the second closing cycle reopens the door
        open = 1'b1;
        step("obs_opening", K_OPENING, 1'b0, 2'd1);
        open = 1'b0;
        steps("obs_opening", 3, K_OPENING, 2'd1);
        step("obs_open", K_OPEN, 1'b0, 2'd1);
        pass_sensor = 1'b1;
        step("obs_closing1", K_CLOSING, 1'b0, 2'd0);
        exp_pass_total++;
        pass_sensor = 1'b0;
        step("obs_closing2", K_CLOSING, 1'b0, 2'd0);
        obstruct = 1'b1;
        step("obs_reopen", K_OPENING, 1'b0, 2'd0);
        obstruct = 1'b0;
        steps("obs_reopening", 3, K_OPENING, 2'd0);
        steps("obs_hold", 8, K_OPEN, 2'd0);
        step("obs_timeout_noalarm", K_CLOSING, 1'b0, 2'd0);
        steps("obs_closing", 3, K_CLOSING, 2'd0);
        step("obs_closed", K_CLOSED, 1'b0, 2'd0);

        // Tailgate while closed
        pass_sensor = 1'b1;
        step("tailgate_alarm", K_CLOSED, 1'b1, 2'd0);
        step("tailgate_level_held", K_CLOSED, 1'b0, 2'd0);
        pass_sensor = 1'b0;
        step("tailgate_clear", K_CLOSED, 1'b0, 2'd0);

        // Credit saturation, simultaneous pass and fare, drain to zero
        open = 1'b1;
        step("sat_opening", K_OPENING, 1'b0, 2'd1);
        step("sat_fare2", K_OPENING, 1'b0, 2'd2);
        step("sat_fare3", K_OPENING, 1'b0, 2'd3);
        step("sat_fare4_saturates", K_OPENING, 1'b0, 2'd3);
        open = 1'b0;
        step("sat_open", K_OPEN, 1'b0, 2'd3);
        pass_sensor = 1'b1;
        step("sat_pass1", K_OPEN, 1'b0, 2'd2);
        exp_pass_total++;
        pass_sensor = 1'b0;
        step("sat_gap", K_OPEN, 1'b0, 2'd2);
        pass_sensor = 1'b1;
        open = 1'b1;
        step("sat_pass_and_fare", K_OPEN, 1'b0, 2'd2);
        exp_pass_total++;
        pass_sensor = 1'b0;
        open = 1'b0;
        step("sat_gap", K_OPEN, 1'b0, 2'd2);
        pass_sensor = 1'b1;
        step("sat_pass2", K_OPEN, 1'b0, 2'd1);
        exp_pass_total++;
        pass_sensor = 1'b0;
        step("sat_gap", K_OPEN, 1'b0, 2'd1);
        pass_sensor = 1'b1;
        step("sat_last_pass", K_CLOSING, 1'b0, 2'd0);
        exp_pass_total++;
        pass_sensor = 1'b0;
        steps("sat_closing", 3, K_CLOSING, 2'd0);
        step("sat_closed", K_CLOSED, 1'b0, 2'd0);

        // Maintenance while open
        open = 1'b1;
        step("mnt_opening", K_OPENING, 1'b0, 2'd1);
        open = 1'b0;
        steps("mnt_opening", 3, K_OPENING, 2'd1);
        step("mnt_open", K_OPEN, 1'b0, 2'd1);
        maintenance = 1'b1;
        step("mnt_closing", K_CLOSING, 1'b0, 2'd0);
        steps("mnt_closing", 3, K_CLOSING, 2'd0);
        step("mnt_closed", K_CLOSED, 1'b0, 2'd0);
        step("mnt_enter", K_MAINT, 1'b0, 2'd0);
        open = 1'b1;
        step("mnt_open_ignored", K_MAINT, 1'b0, 2'd0);
        open = 1'b0;
        step("mnt_idle", K_MAINT, 1'b0, 2'd0);
        pass_sensor = 1'b1;
        step("mnt_tailgate", K_MAINT, 1'b1, 2'd0);
        pass_sensor = 1'b0;
        step("mnt_alarm_clear", K_MAINT, 1'b0, 2'd0);
        maintenance = 1'b0;
        step("mnt_exit", K_CLOSED, 1'b0, 2'd0);

`ifdef GATE_PASS_COUNT_EN
        chk("pass_total", pass_total, 16'(exp_pass_total));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
